// File: rtl/debounce_timer_arbiter_if.sv
// Button-side bundle for debounce_timer_arbiter: raw levels in, press pulses and
// timer ownership status out. The master drives raw; the slave is the debouncer.
interface debounce_timer_arbiter_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] clean;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] grant;
  logic            timer_active;

  modport master (output raw, input clean, busy, grant, timer_active);
  modport slave  (input raw, output clean, busy, grant, timer_active);
endinterface

// File: rtl/debounce_timer_arbiter.sv
// N_CH push-button debouncers sharing one hold-window timer via a round-robin arbiter.
// Optional RAW_SYNC_EN adds a 2-flop synchronizer on every raw input.
module debounce_timer_arbiter #(
  parameter int N_CH         = 4,
  parameter int CW           = 16,
  parameter int DELAY_CYCLES = 50000
) (
  input  logic                      clock,
  input  logic                      reset,
  debounce_timer_arbiter_if.slave   bus
);
  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ_P, S_PRESSED, S_ON, S_WAITING, S_REQ_R, S_RELEASED
  } state_t;

  state_t          state_q [N_CH];
  logic [N_CH-1:0] grant_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   ptr_q;
  logic [N_CH-1:0] raw_s;
  logic [N_CH-1:0] elig;
  logic [N_CH-1:0] win_onehot;
  logic [N_CH-1:0] busy_w;
  logic [N_CH-1:0] clean_w;
  logic [PW-1:0]   win_idx;
  logic            win_valid;
  logic            free;
  logic            delay;
  logic            do_grant;
  int              idx;

`ifdef RAW_SYNC_EN
  logic [N_CH-1:0] sync1_q, sync2_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.raw;
      sync2_q <= sync1_q;
    end
  end
  assign raw_s = sync2_q;
`else
  assign raw_s = bus.raw;
`endif

  // A requester whose raw level already reverted is not eligible, so an abandoned request never wins.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_CH; i++) begin
      elig[i] = ((state_q[i] == S_REQ_P) && raw_s[i]) ||
                ((state_q[i] == S_REQ_R) && !raw_s[i]);
    end
  end

  always_comb begin
    win_valid  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    idx        = 0;
    for (int off = 1; off <= N_CH; off++) begin
      idx = (int'(ptr_q) + off) % N_CH;
      if (!win_valid && elig[PW'(idx)]) begin
        win_valid = 1'b1;
        win_idx   = PW'(idx);
      end
    end
    if (win_valid) win_onehot[win_idx] = 1'b1;
  end

  assign free     = (grant_q == '0);
  assign delay    = (count_q == CW'(DELAY_CYCLES - 1));
  assign do_grant = free && win_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_q <= '0;
      count_q <= '0;
      ptr_q   <= PW'(N_CH - 1);
      for (int i = 0; i < N_CH; i++) state_q[i] <= S_IDLE;
    end else begin
      // Grants only happen while free, so a release always leaves one idle cycle.
      if (do_grant) begin
        grant_q <= win_onehot;
        count_q <= '0;
        ptr_q   <= win_idx;
      end else if (!free) begin
        count_q <= count_q + CW'(1);
        if (delay) grant_q <= '0;
      end

      for (int i = 0; i < N_CH; i++) begin
        case (state_q[i])
          S_IDLE:     if (raw_s[i]) state_q[i] <= S_REQ_P;
          S_REQ_P: begin
            if (!raw_s[i])                                state_q[i] <= S_IDLE;
            else if (do_grant && (win_idx == PW'(i)))     state_q[i] <= S_PRESSED;
          end
          S_PRESSED:  state_q[i] <= S_ON;
          S_ON:       if (delay) state_q[i] <= S_WAITING;
          S_WAITING:  if (!raw_s[i]) state_q[i] <= S_REQ_R;
          S_REQ_R: begin
            if (raw_s[i])                                 state_q[i] <= S_WAITING;
            else if (do_grant && (win_idx == PW'(i)))     state_q[i] <= S_RELEASED;
          end
          S_RELEASED: if (delay) state_q[i] <= S_IDLE;
          default:    state_q[i] <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    busy_w  = '0;
    clean_w = '0;
    for (int i = 0; i < N_CH; i++) begin
      busy_w[i]  = (state_q[i] != S_IDLE);
      clean_w[i] = (state_q[i] == S_PRESSED);
    end
  end

  assign bus.busy         = busy_w;
  assign bus.clean        = clean_w;
  assign bus.grant        = grant_q;
  assign bus.timer_active = |grant_q;
endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Self-checking bench for debounce_timer_arbiter (N_CH=4, DELAY_CYCLES=8); clean pulses
// are checked against a scoreboard of expected (channel, edge) events.
module tb_debounce_timer_arbiter;
  localparam int N = 4;
  localparam int D = 8;
`ifdef RAW_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  typedef struct {
    int ch;
    int at_edge;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  sb_q[$];

  debounce_timer_arbiter_if #(.N_CH(N)) bif();

  debounce_timer_arbiter #(.N_CH(N), .CW(16), .DELAY_CYCLES(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_n <= edge_n + 1;

  // Clean-pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      for (int c = 0; c < N; c++) begin
        if (bif.clean[c]) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL clean_unexpected ch=%0d edge=%0d required none", c, edge_n);
          end else begin
            ev_t e;
            e = sb_q.pop_front();
            if (e.ch !== c || e.at_edge !== edge_n) begin
              errors++;
              $display("FAIL clean_event got ch=%0d edge=%0d required ch=%0d edge=%0d",
                       c, edge_n, e.ch, e.at_edge);
            end else
              $display("clean ch=%0d edge=%0d ok", c, edge_n);
          end
        end
      end
    end
  end

  task automatic push_clean(input int ch, input int at_edge);
    ev_t e;
    e.ch = ch;
    e.at_edge = at_edge;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bif.raw = '0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    @(negedge clock);
    bif.raw = '0;
    n = 0;
    while (bif.busy !== '0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bif.busy !== '0) begin
      errors++;
      $display("FAIL %s_drain busy=%b required 0000 within 200 cycles", name, bif.busy);
    end
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_missing_clean pending=%0d required 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    bif.raw = '0;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bif.clean, bif.busy, bif.grant, bif.timer_active} !== '0) begin
      errors++;
      $display("FAIL reset_state clean=%b busy=%b grant=%b ta=%b required all 0",
               bif.clean, bif.busy, bif.grant, bif.timer_active);
    end else
      $display("reset state ok");
    reset = 1'b1;
  endtask

  task automatic test_single();
    int base;
    logic [N-1:0] eg;
    logic eb;
    do_reset();
    @(negedge clock);
    bif.raw = 4'b0010;
    base = edge_n;
    push_clean(1, base + 2 + S);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clock);
      eg = (((k >= 2 + S) && (k <= 9 + S)) || ((k >= 22 + S) && (k <= 29 + S))) ? 4'b0010 : 4'b0000;
      eb = (k >= 1 + S) && (k <= 29 + S);
      checks++;
      if (bif.grant !== eg || bif.timer_active !== (eg != 0)) begin
        errors++;
        $display("FAIL single_grant k=%0d got %b/%b required %b/%b", k, bif.grant,
                 bif.timer_active, eg, (eg != 0));
      end
      checks++;
      if (bif.busy[1] !== eb) begin
        errors++;
        $display("FAIL single_busy k=%0d got %b required %b", k, bif.busy[1], eb);
      end
      if (k == 20) bif.raw = '0;
    end
    $display("single press/release sequence done");
    drain("single");
  endtask

  task automatic test_pair();
    int base;
    logic [N-1:0] eg;
    do_reset();
    @(negedge clock);
    bif.raw = 4'b0101;
    base = edge_n;
    push_clean(0, base + 2 + S);
    push_clean(2, base + 11 + S);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k >= 2 + S && k <= 9 + S)        eg = 4'b0001;
      else if (k >= 11 + S && k <= 18 + S) eg = 4'b0100;
      else                                  eg = 4'b0000;
      checks++;
      if (bif.grant !== eg) begin
        errors++;
        $display("FAIL pair_grant k=%0d got %b required %b", k, bif.grant, eg);
      end
    end
    $display("simultaneous pair done");
    drain("pair");
  endtask

  task automatic test_all();
    int base;
    logic [N-1:0] exp_g[$];
    logic [N-1:0] prev, want;
    do_reset();
    @(negedge clock);
    bif.raw = 4'b1111;
    base = edge_n;
    for (int c = 0; c < N; c++) begin
      push_clean(c, base + 2 + S + 9 * c);
      exp_g.push_back(4'b0001 << c);
    end
    for (int c = 0; c < N; c++) exp_g.push_back(4'b0001 << c);
    prev = '0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (bif.grant !== prev) begin
        if (prev != 0 && bif.grant != 0) begin
          checks++;
          errors++;
          $display("FAIL all_no_gap k=%0d got %b after %b required free cycle", k, bif.grant, prev);
        end
        if (bif.grant != 0) begin
          checks++;
          if (exp_g.size() == 0) begin
            errors++;
            $display("FAIL all_grant_order k=%0d got %b required none", k, bif.grant);
          end else begin
            want = exp_g.pop_front();
            if (bif.grant !== want) begin
              errors++;
              $display("FAIL all_grant_order k=%0d got %b required %b", k, bif.grant, want);
            end
          end
        end
        prev = bif.grant;
      end
      if (k == 45) bif.raw = '0;
    end
    checks++;
    if (exp_g.size() !== 0) begin
      errors++;
      $display("FAIL all_grants_missing got %0d pending required 0", exp_g.size());
    end
    $display("four-channel round robin done");
    drain("all");
  endtask

  task automatic test_abandon();
    int base;
    do_reset();
    @(negedge clock);
    bif.raw = 4'b0001;
    base = edge_n;
    push_clean(0, base + 2 + S);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clock);
      if (k == 3) bif.raw[3] = 1'b1;
      if (k == 6) bif.raw[3] = 1'b0;
      if (k == 9 + S) begin
        checks++;
        if (bif.grant !== 4'b0001 || bif.busy[3] !== 1'b0) begin
          errors++;
          $display("FAIL abandon_mid grant=%b busy3=%b required 0001/0", bif.grant, bif.busy[3]);
        end
      end
    end
    checks++;
    if (bif.grant !== 4'b0000) begin
      errors++;
      $display("FAIL abandon_after grant=%b required 0000", bif.grant);
    end
    $display("abandoned request done");
    drain("abandon");
  endtask

  task automatic test_async_reset();
    int base;
    do_reset();
    @(negedge clock);
    bif.raw = 4'b0010;
    base = edge_n;
    push_clean(1, base + 2 + S);
    repeat (5 + S) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({bif.grant, bif.busy, bif.clean} !== '0) begin
      errors++;
      $display("FAIL async_reset grant=%b busy=%b clean=%b required 0",
               bif.grant, bif.busy, bif.clean);
    end
    @(negedge clock);
    reset = 1'b1;
    base = edge_n;
    push_clean(1, base + 2 + S);
    repeat (4 + S) @(negedge clock);
    $display("async reset mid-ON done");
    drain("areset");
  endtask

  initial begin
    bif.raw = '0;
    test_reset();
    test_single();
    test_pair();
    test_all();
    test_abandon();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout required finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
